// File: rtl/syn_fifo_pkg.sv
// Shared constants for the synchronous FIFO family and its read-side stream adapter.
package syn_fifo_pkg;

  localparam int BUF_DEPTH   = 3;
  localparam int BUF_PTR_W   = 2;
  localparam int FIFO_RD_LAT = 1;

  // Advance a circular-buffer pointer, wrapping at BUF_DEPTH.
  function automatic logic [BUF_PTR_W-1:0] ptr_inc(input logic [BUF_PTR_W-1:0] p);
    return (p == BUF_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + BUF_PTR_W'(1);
  endfunction

endpackage

// File: rtl/syn_fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the read adapter.
interface syn_fifo_rd_stream_if #(
  parameter int P_DATA_W = 8
);

  logic                i_fifo_empty;
  logic [P_DATA_W-1:0] i_fifo_data;
  logic                o_fifo_rd_en;
  logic                o_valid;
  logic [P_DATA_W-1:0] o_data;
  logic                i_ready;

  // The adapter side: reads the FIFO, sources the stream.
  modport master (
    input  i_fifo_empty, i_fifo_data, i_ready,
    output o_fifo_rd_en, o_valid, o_data
  );

  // The environment side: the FIFO and the stream consumer.
  modport slave (
    output i_fifo_empty, i_fifo_data, i_ready,
    input  o_fifo_rd_en, o_valid, o_data
  );

endinterface

// File: rtl/stream_elastic_buf3.sv
// Three-entry circular buffer with push/pop/flush; head word is presented on dout.
// When empty, dout keeps the last popped word so the stream data never glitches.
module stream_elastic_buf3
  import syn_fifo_pkg::*;
#(
  parameter int P_DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [P_DATA_W-1:0]  din,
  output logic [P_DATA_W-1:0]  dout,
  output logic [BUF_PTR_W-1:0] level
);

  logic [P_DATA_W-1:0]  mem [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] head;
  logic [BUF_PTR_W-1:0] tail;
  logic [P_DATA_W-1:0]  last_q;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (level != '0) && !flush;
  assign dout    = (level != '0) ? mem[head] : last_q;

  // Pointer and occupancy bookkeeping; flush collapses the buffer to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (do_push) tail <= ptr_inc(tail);
      if (do_pop)  head <= ptr_inc(head);
      level <= level + BUF_PTR_W'(do_push) - BUF_PTR_W'(do_pop);
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[tail] <= din;
    end
  end

  // Remember the word leaving the head so dout holds it once the buffer drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (do_pop) begin
      last_q <= mem[head];
    end
  end

endmodule

// File: rtl/syn_fifo_rd_stream.sv
// Read-side adapter for syn_fifo: issues reads against buffer credits so that
// rd_en never depends on i_ready, and streams the buffered words out.
module syn_fifo_rd_stream
  import syn_fifo_pkg::*;
#(
  parameter int P_DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  syn_fifo_rd_stream_if.master bus,
  input  logic                 i_flush,
  output logic [BUF_PTR_W-1:0] o_level
);

  logic [FIFO_RD_LAT-1:0] inflight;
  logic [BUF_PTR_W-1:0]   level;
  logic [BUF_PTR_W:0]     credits_used;

  // A read is outstanding for each cycle of FIFO latency, so it already owns a slot.
  assign credits_used = {1'b0, level} + {{BUF_PTR_W{1'b0}}, inflight};

  // Reset gates the request so the FIFO sees no read while the adapter is held.
  assign bus.o_fifo_rd_en = !rst && !bus.i_fifo_empty && !i_flush &&
                            (credits_used < (BUF_PTR_W + 1)'(BUF_DEPTH));

  assign bus.o_valid = (level != '0);
  assign o_level     = level;

  // Track the read issued last cycle; its data lands on i_fifo_data this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight <= bus.o_fifo_rd_en;
    end
  end

  stream_elastic_buf3 #(
    .P_DATA_W (P_DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (bus.o_valid && bus.i_ready),
    .flush (i_flush),
    .din   (bus.i_fifo_data),
    .dout  (bus.o_data),
    .level (level)
  );

endmodule

// File: tb/tb_syn_fifo_rd_stream.sv
// Bench for syn_fifo_rd_stream: a behavioural one-cycle-latency FIFO feeds the
// adapter; expected stream words are queued as they are loaded and checked on beats.
module tb_syn_fifo_rd_stream;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] level;

  syn_fifo_rd_stream_if #(.P_DATA_W(8)) bus();

  syn_fifo_rd_stream #(.P_DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .i_flush (flush),
    .o_level (level)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: storage written by the stimulus, read side owned here.
  logic [7:0] fmem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic       fifo_rst;

  assign bus.i_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rst) begin
      rd_ptr <= wr_ptr;
    end else if (bus.o_fifo_rd_en && !bus.i_fifo_empty) begin
      bus.i_fifo_data <= fmem[rd_ptr];
      rd_ptr          <= rd_ptr + 8'd1;
    end
  end

  int         vectors;
  int         miscompares;
  logic [7:0] sb [$];

  task automatic load(input logic [7:0] w, input bit expect_out);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    if (expect_out) sb.push_back(w);
  endtask

  task automatic test_reset();
    @(negedge clk);
    fifo_rst = 0;
    #2;
    vectors++;
    if ({bus.o_fifo_rd_en, bus.o_valid, bus.o_data, level} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: rd_en=%b valid=%b data=%h level=%0d, required all 0",
               bus.o_fifo_rd_en, bus.o_valid, bus.o_data, level);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.o_fifo_rd_en !== 1'b0 || bus.o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset: rd_en=%b valid=%b, required 0 0", bus.o_fifo_rd_en, bus.o_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    int rd_cnt = 0, rd_first = -1, vl_cnt = 0, vl_first = -1;
    logic [7:0] exp;
    bus.i_ready = 1;
    @(negedge clk);
    load(8'hA5, 1);
    for (int i = 0; i < 7; i++) begin
      #1;
      if (bus.o_fifo_rd_en) begin if (rd_first < 0) rd_first = i; rd_cnt++; end
      if (bus.o_valid)      begin if (vl_first < 0) vl_first = i; vl_cnt++; end
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL single_extra_beat: got %h, required no beat", bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            miscompares++;
            $display("FAIL single_data: got %h, required %h", bus.o_data, exp);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (rd_cnt !== 1 || rd_first !== 0) begin
      miscompares++;
      $display("FAIL single_rd_en: %0d cycles from %0d, required 1 from 0", rd_cnt, rd_first);
    end
    vectors++;
    if (vl_cnt !== 1 || vl_first !== 2) begin
      miscompares++;
      $display("FAIL single_valid: %0d cycles from %0d, required 1 from 2", vl_cnt, vl_first);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL single_missing: %0d words undelivered, required 0", sb.size());
    end
  endtask

  task automatic test_burst();
    int rd_cnt = 0, rd_first = -1, rd_last = -1, vl_cnt = 0, vl_first = -1, vl_last = -1;
    logic [7:0] exp;
    bus.i_ready = 1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) load(8'h10 + 8'(k), 1);
    for (int i = 0; i < 14; i++) begin
      #1;
      if (bus.o_fifo_rd_en) begin if (rd_first < 0) rd_first = i; rd_last = i; rd_cnt++; end
      if (bus.o_valid)      begin if (vl_first < 0) vl_first = i; vl_last = i; vl_cnt++; end
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL burst_extra_beat: got %h, required no beat", bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            miscompares++;
            $display("FAIL burst_data: got %h, required %h", bus.o_data, exp);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (rd_cnt !== 8 || rd_first !== 0 || rd_last !== 7) begin
      miscompares++;
      $display("FAIL burst_rd_en: %0d cycles %0d..%0d, required 8 cycles 0..7", rd_cnt, rd_first, rd_last);
    end
    vectors++;
    if (vl_cnt !== 8 || vl_first !== 2 || vl_last !== 9) begin
      miscompares++;
      $display("FAIL burst_valid: %0d cycles %0d..%0d, required 8 cycles 2..9", vl_cnt, vl_first, vl_last);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL burst_missing: %0d words undelivered, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    bus.i_ready = 0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) load(8'h20 + 8'(k), 1);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i >= 2) begin
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h20) begin
          miscompares++;
          $display("FAIL bp_hold: valid=%b data=%h, required 1 20", bus.o_valid, bus.o_data);
        end
      end
      if (level == 2'd3 && bus.o_fifo_rd_en) begin
        vectors++;
        miscompares++;
        $display("FAIL bp_overissue: rd_en=1 at level 3, required 0");
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (level !== 2'd3 || bus.o_fifo_rd_en !== 1'b0 || (wr_ptr - rd_ptr) !== 8'd3) begin
      miscompares++;
      $display("FAIL bp_full: level=%0d rd_en=%b fifo_left=%0d, required 3 0 3",
               level, bus.o_fifo_rd_en, wr_ptr - rd_ptr);
    end
    @(negedge clk);
    bus.i_ready = 1;
    #1;
    vectors++;
    if (bus.o_fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_pop_cycle_rd_en: got %b, required 0", bus.o_fifo_rd_en);
    end
    if (bus.o_valid && bus.i_ready) begin
      vectors++;
      exp = sb.pop_front();
      if (bus.o_data !== exp) begin
        miscompares++;
        $display("FAIL bp_data: got %h, required %h", bus.o_data, exp);
      end
    end
    @(negedge clk);
    bus.i_ready = 0;
    #1;
    vectors++;
    if (bus.o_fifo_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_credit_return: rd_en=%b, required 1", bus.o_fifo_rd_en);
    end
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      bus.i_ready = (i % 2 == 0);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra_beat: got %h, required no beat", bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            miscompares++;
            $display("FAIL bp_data: got %h, required %h", bus.o_data, exp);
          end
        end
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (sb.size() !== 0 || level !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_drain: %0d undelivered level=%0d, required 0 0", sb.size(), level);
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp;
    bus.i_ready = 0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) load(8'h40 + 8'(k), k >= 3);
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (level !== 2'd2 || bus.o_fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_setup: level=%0d rd_en=%b, required 2 0", level, bus.o_fifo_rd_en);
    end
    flush = 1;
    #1;
    vectors++;
    if (bus.o_fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_rd_en: got %b, required 0", bus.o_fifo_rd_en);
    end
    @(negedge clk);
    flush = 0;
    #1;
    vectors++;
    if (level !== 2'd0 || bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: level=%0d valid=%b, required 0 0", level, bus.o_valid);
    end
    @(negedge clk);
    bus.i_ready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL flush_extra_beat: got %h, required no beat", bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            miscompares++;
            $display("FAIL flush_data: got %h, required %h", bus.o_data, exp);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL flush_missing: %0d words undelivered, required 0", sb.size());
    end
  endtask

  task automatic test_reset_burst();
    logic [7:0] exp;
    bus.i_ready = 1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) load(8'h50 + 8'(k), 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        exp = sb.pop_front();
        if (bus.o_data !== exp) begin
          miscompares++;
          $display("FAIL rb_data: got %h, required %h", bus.o_data, exp);
        end
      end
      @(negedge clk);
    end
    #2;
    rst = 1;
    #1;
    vectors++;
    if ({bus.o_fifo_rd_en, bus.o_valid, bus.o_data, level} !== 12'h000) begin
      miscompares++;
      $display("FAIL rb_async_clear: rd_en=%b valid=%b data=%h level=%0d, required all 0",
               bus.o_fifo_rd_en, bus.o_valid, bus.o_data, level);
    end
    sb.delete();
    fifo_rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fifo_rst = 0;
    rst = 0;
    @(negedge clk);
    load(8'h30, 1);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rb_extra_beat: got %h, required no beat", bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            miscompares++;
            $display("FAIL rb_first_beat: got %h, required %h", bus.o_data, exp);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL rb_missing: %0d words undelivered, required 0", sb.size());
    end
  endtask

  initial begin
    clk         = 0;
    rst         = 1;
    flush       = 0;
    fifo_rst    = 1;
    wr_ptr      = 0;
    bus.i_ready = 0;
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_flush();
    test_reset_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/syn_fifo_rd_stream.md
# syn_fifo_rd_stream

Read-side companion for the team's synchronous FIFO. It drives the FIFO read port (`rd_en`, `empty`, one-cycle registered read data) and presents the words downstream as a valid/ready stream. A 3-entry elastic buffer with credit-based read issue sustains one word per cycle, and `o_fifo_rd_en` never depends combinationally on `i_ready`. It sits between any `syn_fifo` instance and a stream consumer.

## Interface
- `P_DATA_W`, default 8: data width; must match the attached FIFO.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `i_fifo_data`  in  `P_DATA_W`  FIFO read data, valid the cycle after an accepted `o_fifo_rd_en`.
- `o_fifo_rd_en`  out  1  FIFO read request.
- `o_valid`  out  1  stream word available.
- `o_data`  out  `P_DATA_W`  stream word (head of buffer).
- `i_ready`  in  1  consumer accepts; a beat transfers when `o_valid && i_ready`.
- `i_flush`  in  1  synchronous flush of buffer and in-flight word.
- `o_level`  out  2  buffer occupancy, 0..3.

## Operation
- Reset values: `o_fifo_rd_en`=0, `o_valid`=0, `o_data`=0, `o_level`=0, all buffer entries 0, `inflight`=0.
- `inflight` is a 1-bit register equal to the previous cycle's `o_fifo_rd_en`. The FIFO read latency is fixed at 1.
- Issue rule (combinational): `o_fifo_rd_en = !i_fifo_empty && !i_flush && (level + inflight) < 3`.
- Capture: when `inflight && !i_flush`, `i_fifo_data` is written at the tail and the tail advances modulo 3.
- Pop: on `o_valid && i_ready`, the head advances modulo 3.
- Push and pop in the same cycle are legal: level is unchanged and order is preserved.
- `o_valid = (level != 0)`. `o_data` = entry at head. When level = 0, `o_data` holds the last popped value (0 after reset).
- Level arithmetic is 2-bit: `level_next = level + push - pop`. Overflow is impossible by the issue rule; the bench asserts `level` ≤ 3 and no push when `level` = 3 without a pop.
- Flush: level, head and tail go to 0. The word arriving that cycle (if `inflight`) is discarded. `o_fifo_rd_en` is held 0 during the flush cycle, so nothing is in flight afterwards. The FIFO contents themselves are not drained.
- Stream rule: once `o_valid` is 1, `o_valid` and `o_data` stay stable until the beat transfers. The only exceptions are flush and reset.

## Timing
- First word: FIFO goes non-empty in cycle N with the block idle. `o_fifo_rd_en` rises in N, data is on `i_fifo_data` in N+1 and is captured at the end of N+1. `o_valid` rises in N+2 (latency 2).
- Steady state with `i_ready`=1 and the FIFO non-empty: `level`=1 and `inflight`=1. `o_fifo_rd_en` is high every cycle and one beat transfers every cycle.
- Backpressure: with `i_ready`=0, `level` reaches 3 at most 2 cycles after `o_fifo_rd_en` last rose. `o_fifo_rd_en` is 0 whenever `level + inflight` = 3.
- When `i_ready` returns, a pop in cycle M frees a credit. `o_fifo_rd_en` reasserts in M+1.
- Async `rst` mid-operation: all state is cleared immediately, independent of `clk`. Any FIFO word already read is lost; this is accepted. The FIFO reset is separate.

## Structure
- Shared package `syn_fifo_pkg` holds `BUF_DEPTH` = 3 and `BUF_PTR_W` = 2, plus the FIFO read-latency constant (1).
- Sub-module `stream_elastic_buf3`: a 3-entry circular buffer with push/pop/flush, head/tail/level and head-data output. The top level holds the issue logic and the `inflight` flag only.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; after release with FIFO empty, `o_fifo_rd_en` stays 0.
- Single word: FIFO loaded with 0xA5, `i_ready`=1 -> `o_fifo_rd_en` high 1 cycle. `o_valid`=1 with `o_data`=0xA5 two cycles later, for exactly 1 cycle.
- Burst: 0x10..0x17 with `i_ready`=1 -> `o_fifo_rd_en` high 8 consecutive cycles. 8 consecutive beats 0x10..0x17 follow, starting 2 cycles later.
- Backpressure: 6 words 0x20..0x25 with `i_ready`=0 -> `o_level`=3 and `o_fifo_rd_en`=0 with 3 words left in the FIFO. `o_data`=0x20 is stable throughout. Toggling `i_ready` 1/0 then delivers 0x20..0x25 in order with no loss or duplication.
- Flush: `i_flush` pulsed while `level`=2 and `inflight`=1 -> next cycle `o_level`=0 and `o_valid`=0. The in-flight word is never output. Reading then resumes from the next FIFO word.
- Reset mid-burst: `rst` asserted during a 1-per-cycle stream -> `o_valid`/`o_fifo_rd_en` drop immediately. After release, with the FIFO reset and reloaded with 0x30, the first beat is 0x30.
